// File: rtl/ace_snoop_responder.sv
// ACE snoop-channel terminator: accepts AC snoops, looks the line up in the local cache, answers on CR,
// streams the line on CD when data transfer is required, then applies the state update.
// Optional statistics counters are enabled with `define ACE_SNOOP_RESP_STATS_EN.
module ace_snoop_responder #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int LineWidth = 512,
  parameter int CntWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ac_valid_i,
  output logic                 ac_ready_o,
  input  logic [AddrWidth-1:0] ac_addr_i,
  input  logic [3:0]           ac_snoop_i,
  input  logic [2:0]           ac_prot_i,
  output logic                 cr_valid_o,
  input  logic                 cr_ready_i,
  output logic [4:0]           cr_resp_o,
  output logic                 cd_valid_o,
  input  logic                 cd_ready_i,
  output logic [DataWidth-1:0] cd_data_o,
  output logic                 cd_last_o,
  output logic                 lkp_valid_o,
  input  logic                 lkp_ready_i,
  output logic [AddrWidth-1:0] lkp_addr_o,
  input  logic                 lkp_rsp_valid_i,
  input  logic                 lkp_hit_i,
  input  logic                 lkp_dirty_i,
  input  logic                 lkp_shared_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 upd_valid_o,
  input  logic                 upd_ready_i,
  output logic [1:0]           upd_op_o
`ifdef ACE_SNOOP_RESP_STATS_EN
  ,
  output logic [CntWidth-1:0]  stat_hits_o,
  output logic [CntWidth-1:0]  stat_misses_o,
  output logic [CntWidth-1:0]  stat_dirty_o
`endif
);

  localparam int Beats = LineWidth / DataWidth;
  localparam int OffW  = $clog2(LineWidth / 8);
  localparam int BcW   = (Beats > 1) ? $clog2(Beats) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LKP, S_WAIT, S_RESP, S_DATA, S_UPD
  } state_e;

  state_e                  r_state;
  logic [BcW-1:0]          r_beat;
  logic [AddrWidth-OffW-1:0] r_line;
  logic [3:0]              r_snoop;
  logic [4:0]              r_resp;
  logic [1:0]              r_op;
  logic                    w_ac_hs;
  logic                    w_cd_hs;
  logic                    w_in_data;
  logic                    w_unused;

  // Returns {op, resp}; resp bits are {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
  function automatic logic [6:0] f_snoop(input logic [3:0] snp, input logic hit,
                                         input logic dirty, input logic shared);
    logic [4:0] resp;
    logic [1:0] op;
    resp = '0;
    op   = 2'd0;
    case (snp)
      4'b0000: if (hit) resp = {!shared, 1'b1, 1'b0, 1'b0, 1'b1};
      4'b0001, 4'b0010, 4'b0011: if (hit) begin
        resp = {!shared, 1'b1, dirty, 1'b0, 1'b1};
        op   = 2'd1;
      end
      4'b0111: if (hit) begin
        resp = {!shared, 1'b0, dirty, 1'b0, 1'b1};
        op   = 2'd3;
      end
      4'b1000: if (hit) begin
        resp = {!shared, 1'b1, dirty, 1'b0, dirty};
        op   = dirty ? 2'd2 : 2'd0;
      end
      4'b1001: if (hit) begin
        resp = {!shared, 1'b0, dirty, 1'b0, dirty};
        op   = 2'd3;
      end
      4'b1101: if (hit) begin
        resp = {!shared, 4'b0000};
        op   = 2'd3;
      end
      default: resp = 5'b00010;
    endcase
    return {op, resp};
  endfunction

  assign w_unused  = ^{ac_prot_i, ac_addr_i[OffW-1:0]};
  assign w_in_data = (r_state == S_DATA);
  assign w_ac_hs   = ac_valid_i && ac_ready_o;
  assign w_cd_hs   = w_in_data && data_valid_i && cd_ready_i;

  // Reset holds off new snoops so nothing is accepted while the block is being cleared.
  assign ac_ready_o   = (r_state == S_IDLE) && !rst_i;
  assign lkp_valid_o  = (r_state == S_LKP);
  assign lkp_addr_o   = lkp_valid_o ? {r_line, {OffW{1'b0}}} : '0;
  assign cr_valid_o   = (r_state == S_RESP);
  assign cr_resp_o    = cr_valid_o ? r_resp : '0;
  assign data_ready_o = w_in_data && cd_ready_i;
  assign cd_valid_o   = w_in_data && data_valid_i;
  assign cd_data_o    = w_in_data ? data_i : '0;
  assign cd_last_o    = w_in_data && (r_beat == BcW'(Beats - 1));
  assign upd_valid_o  = (r_state == S_UPD);
  assign upd_op_o     = upd_valid_o ? r_op : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_ac_hs) r_state <= S_LKP;
        S_LKP:  if (lkp_ready_i) r_state <= S_WAIT;
        S_WAIT: if (lkp_rsp_valid_i) r_state <= S_RESP;
        S_RESP: if (cr_ready_i) begin
          if (r_resp[0])          r_state <= S_DATA;
          else if (r_op != 2'd0)  r_state <= S_UPD;
          else                    r_state <= S_IDLE;
        end
        S_DATA: if (w_cd_hs) begin
          if (r_beat == BcW'(Beats - 1)) begin
            r_beat  <= '0;
            r_state <= (r_op != 2'd0) ? S_UPD : S_IDLE;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        S_UPD:  if (upd_ready_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Snoop context and response are pure data: qualified by state, never reset.
  always_ff @(posedge clk_i) begin
    if (w_ac_hs) begin
      r_line  <= ac_addr_i[AddrWidth-1:OffW];
      r_snoop <= ac_snoop_i;
    end
    if ((r_state == S_WAIT) && lkp_rsp_valid_i) begin
      {r_op, r_resp} <= f_snoop(r_snoop, lkp_hit_i, lkp_dirty_i, lkp_shared_i);
    end
  end

`ifdef ACE_SNOOP_RESP_STATS_EN
  logic [CntWidth-1:0] r_hits;
  logic [CntWidth-1:0] r_misses;
  logic [CntWidth-1:0] r_dirty;

  function automatic logic [CntWidth-1:0] f_sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hits   <= '0;
      r_misses <= '0;
      r_dirty  <= '0;
    end else if ((r_state == S_WAIT) && lkp_rsp_valid_i) begin
      if (lkp_hit_i)                r_hits   <= f_sat_inc(r_hits);
      if (!lkp_hit_i)               r_misses <= f_sat_inc(r_misses);
      if (lkp_hit_i && lkp_dirty_i) r_dirty  <= f_sat_inc(r_dirty);
    end
  end

  assign stat_hits_o   = r_hits;
  assign stat_misses_o = r_misses;
  assign stat_dirty_o  = r_dirty;
`endif

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Scoreboard bench for ace_snoop_responder: a driver queues expected lookups, responses, beats and
// updates from a behavioural snoop model; a negedge monitor pops and compares on every handshake.
module tb_ace_snoop_responder;
  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int LW    = 512;
  localparam int BEATS = LW / DW;
  localparam int LINEB = LW / 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          ac_valid_i = 1'b0, ac_ready_o;
  logic [AW-1:0] ac_addr_i = '0;
  logic [3:0]    ac_snoop_i = '0;
  logic [2:0]    ac_prot_i = '0;
  logic          cr_valid_o, cr_ready_i = 1'b0;
  logic [4:0]    cr_resp_o;
  logic          cd_valid_o, cd_ready_i = 1'b0, cd_last_o;
  logic [DW-1:0] cd_data_o;
  logic          lkp_valid_o, lkp_ready_i = 1'b0;
  logic [AW-1:0] lkp_addr_o;
  logic          lkp_rsp_valid_i = 1'b0, lkp_hit_i = 1'b0, lkp_dirty_i = 1'b0, lkp_shared_i = 1'b0;
  logic          data_valid_i = 1'b0, data_ready_o;
  logic [DW-1:0] data_i = '0;
  logic          upd_valid_o, upd_ready_i = 1'b0;
  logic [1:0]    upd_op_o;

  always #5 clk = ~clk;

  ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .LineWidth(LW), .CntWidth(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
    .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
    .lkp_valid_o(lkp_valid_o), .lkp_ready_i(lkp_ready_i), .lkp_addr_o(lkp_addr_o),
    .lkp_rsp_valid_i(lkp_rsp_valid_i), .lkp_hit_i(lkp_hit_i), .lkp_dirty_i(lkp_dirty_i),
    .lkp_shared_i(lkp_shared_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
    .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_op_o(upd_op_o)
  );

  typedef struct { logic [DW-1:0] d; logic last; } beat_t;

  int total = 0;
  int bad = 0;
  logic [4:0]    exp_cr_q[$];
  logic [AW-1:0] exp_lkp_q[$];
  beat_t         exp_cd_q[$];
  logic [1:0]    exp_upd_q[$];
  logic [2:0]    rsp_q[$];
  logic [DW-1:0] prov_q[$];
  bit busy = 0, zw = 0, lkp_hs_f = 0, data_hs_f = 0, rsp_pend = 0, lat_pend = 0, cr_prev_pend = 0;
  int cr_mode = 0, cd_mode = 0, cd_cnt = 0, cyc = 0, ac_cyc = 0, rsp_dly = 0, cr_vcnt = 0;
  logic [4:0] cr_prev_val = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic die(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting on the DUT", name);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Snoop semantics from the protocol tables, expressed per response field.
  function automatic void model(input logic [3:0] s, input bit h, input bit d, input bit sh,
                                output logic [4:0] cr, output bit dt, output logic [1:0] op);
    bit known, rd, cln, pd, is;
    known = (s <= 4'd3) || (s == 4'd7) || (s == 4'd8) || (s == 4'd9) || (s == 4'd13);
    cr = '0; dt = 0; op = 2'd0;
    if (!known) begin
      cr = 5'b00010;
      return;
    end
    if (!h) return;
    rd  = (s <= 4'd3) || (s == 4'd7);
    cln = (s == 4'd8) || (s == 4'd9);
    dt  = rd || (cln && d);
    pd  = d && (s != 4'd0) && (s != 4'd13);
    is  = (s <= 4'd3) || (s == 4'd8);
    if (s == 4'd7 || s == 4'd9 || s == 4'd13) op = 2'd3;
    else if (s >= 4'd1 && s <= 4'd3)          op = 2'd1;
    else if (s == 4'd8 && d)                  op = 2'd2;
    cr = {!sh, is, pd, 1'b0, dt};
  endfunction

  always @(posedge clk) cyc++;

  // Environment: lookup port, cache data source and the downstream ready signals.
  initial begin
    logic [2:0] r3;
    forever begin
      @(posedge clk); #1;
      lkp_ready_i = zw ? 1'b1 : ($urandom_range(0, 3) != 0);
      lkp_rsp_valid_i = 1'b0;
      {lkp_hit_i, lkp_dirty_i, lkp_shared_i} = 3'($urandom);
      if (lkp_hs_f) begin
        lkp_hs_f = 0;
        rsp_pend = 1;
        rsp_dly  = zw ? 0 : $urandom_range(0, 3);
      end
      if (rsp_pend) begin
        if (rsp_dly == 0) begin
          rsp_pend = 0;
          if (rsp_q.size() > 0) begin
            r3 = rsp_q.pop_front();
            lkp_rsp_valid_i = 1'b1;
            {lkp_hit_i, lkp_dirty_i, lkp_shared_i} = r3;
          end
        end else rsp_dly--;
      end
      if (data_hs_f) begin
        data_hs_f = 0;
        if (prov_q.size() > 0) prov_q.delete(0);
        data_valid_i = 1'b0;
      end
      if (rst_i || prov_q.size() == 0) data_valid_i = 1'b0;
      else if (!data_valid_i) data_valid_i = zw || ($urandom_range(0, 2) != 0);
      data_i = (prov_q.size() > 0) ? prov_q[0] : DW'($urandom);
      case (cd_mode)
        1: cd_ready_i = !cd_ready_i;
        2: cd_ready_i = 1'b1;
        default: cd_ready_i = zw ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      if (cr_valid_o) cr_vcnt++; else cr_vcnt = 0;
      if (cr_mode == 1) cr_ready_i = (cr_vcnt > 5);
      else cr_ready_i = zw ? 1'b1 : ($urandom_range(0, 2) != 0);
      upd_ready_i = zw ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares every handshake against the head of its expectation queue.
  always @(negedge clk) begin
    beat_t b;
    if (busy) check("ac_ready_while_busy", ac_ready_o, 0);
    if (lat_pend && cr_valid_o) begin
      lat_pend = 0;
      check("cr_latency", cyc - ac_cyc, 3);
    end
    if (ac_valid_i && ac_ready_o) begin
      busy = 1;
      ac_cyc = cyc;
      lat_pend = zw;
    end
    if (lkp_valid_o && lkp_ready_i) begin
      lkp_hs_f = 1;
      if (exp_lkp_q.size() == 0) check("unexpected_lkp", 1, 0);
      else check("lkp_addr", lkp_addr_o, exp_lkp_q.pop_front());
    end
    if (cr_prev_pend) check("cr_stable", {cr_valid_o, cr_resp_o}, {1'b1, cr_prev_val});
    cr_prev_pend = cr_valid_o && !cr_ready_i;
    cr_prev_val  = cr_resp_o;
    if (cr_valid_o && cr_ready_i) begin
      if (exp_cr_q.size() == 0) check("unexpected_cr", 1, 0);
      else check("cr_resp", cr_resp_o, exp_cr_q.pop_front());
    end
    if (data_valid_i && data_ready_o) data_hs_f = 1;
    if (cd_valid_o && cd_ready_i) begin
      cd_cnt++;
      if (exp_cd_q.size() == 0) check("unexpected_cd", 1, 0);
      else begin
        b = exp_cd_q.pop_front();
        check("cd_beat", {cd_last_o, cd_data_o}, {b.last, b.d});
      end
    end
    if (upd_valid_o && upd_ready_i) begin
      if (exp_upd_q.size() == 0) check("unexpected_upd", 1, 0);
      else check("upd_op", upd_op_o, exp_upd_q.pop_front());
    end
    if (busy && exp_cr_q.size() == 0 && exp_lkp_q.size() == 0 &&
        exp_cd_q.size() == 0 && exp_upd_q.size() == 0) busy = 0;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy) begin
      @(negedge clk);
      n++;
      if (n > 3000) die("idle_wait");
    end
  endtask

  task automatic snoop(input logic [AW-1:0] addr, input logic [3:0] s, input bit h, input bit d,
                       input bit sh, input bit zw_i);
    logic [4:0] cr;
    bit dt;
    logic [1:0] op;
    beat_t b;
    int n;
    wait_idle();
    zw = zw_i;
    model(s, h, d, sh, cr, dt, op);
    exp_lkp_q.push_back((addr / LINEB) * LINEB);
    exp_cr_q.push_back(cr);
    rsp_q.push_back({h, d, sh});
    if (dt) for (int i = 0; i < BEATS; i++) begin
      b.d = {$urandom, $urandom};
      b.last = (i == BEATS - 1);
      exp_cd_q.push_back(b);
      prov_q.push_back(b.d);
    end
    if (op != 2'd0) exp_upd_q.push_back(op);
    @(posedge clk); #1;
    ac_valid_i = 1'b1;
    ac_addr_i  = addr;
    ac_snoop_i = s;
    ac_prot_i  = 3'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 100) die("ac_handshake");
    end while (!ac_ready_o);
    @(posedge clk); #1;
    ac_valid_i = 1'b0;
  endtask

  initial begin
    int n, start;
    bit quiet;
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, start;
    bit quiet;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset_ctrl", {ac_ready_o, cr_valid_o, cd_valid_o, lkp_valid_o, data_ready_o, upd_valid_o,
                         cd_last_o, cr_resp_o, upd_op_o}, {1'b1, 13'd0});
    check("reset_data", {lkp_addr_o, cd_data_o}, 128'd0);

    snoop(64'h1000, 4'b0001, 1, 1, 0, 1);
    snoop(64'h2040, 4'b0111, 1, 0, 1, 1);
    snoop(64'h3a00, 4'b1000, 1, 0, 0, 1);
    snoop(64'h3a00, 4'b1000, 0, 0, 0, 1);
    snoop(64'h4abc, 4'b0101, 1, 1, 0, 0);
    wait_idle();
    cr_mode = 1;
    cd_mode = 1;
    snoop(64'h5040, 4'b0000, 1, 0, 0, 0);
    wait_idle();
    cr_mode = 0;
    cd_mode = 0;

    start = cd_cnt;
    snoop(64'h6000, 4'b0001, 1, 1, 0, 1);
    n = 0;
    while (cd_cnt < start + 3) begin
      @(negedge clk);
      n++;
      if (n > 100) die("reset_mid_data");
    end
    @(posedge clk); #2;
    rst_i = 1'b1;
    data_valid_i = 1'b0;
    exp_cr_q.delete(); exp_lkp_q.delete(); exp_cd_q.delete(); exp_upd_q.delete();
    prov_q.delete(); rsp_q.delete();
    busy = 0; rsp_pend = 0; lat_pend = 0;
    @(posedge clk); #2;
    rst_i = 1'b0;
    @(negedge clk);
    check("midreset_ctrl", {ac_ready_o, cr_valid_o, cd_valid_o, lkp_valid_o, data_ready_o, upd_valid_o,
                            cd_last_o, cr_resp_o, upd_op_o}, {1'b1, 13'd0});
    check("midreset_data", {lkp_addr_o, cd_data_o}, 128'd0);
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      quiet |= cd_valid_o | upd_valid_o | cr_valid_o | lkp_valid_o | !ac_ready_o;
    end
    check("post_reset_quiet", quiet, 0);

    for (int i = 0; i < 80; i++) begin
      cd_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      snoop({$urandom, $urandom}, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) == 0);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check("queues_drained", exp_cr_q.size() + exp_lkp_q.size() + exp_cd_q.size() + exp_upd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
